// File: rtl/fetch_pkg.sv
// ---- fetch_pkg: FSM encoding, buffer entry type and redirect target helpers for fetch_unit -- rev 1.0 ----
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] instr);
    logic [31:0] seq;
    seq = pc + 32'd4;
    return seq + {{14{instr[15]}}, instr[15:0], 2'b00};
  endfunction

  // The region bits come from the delay-slot address, not the branch itself.
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] instr);
    logic [31:0] tgt;
    tgt       = pc + 32'd4;
    tgt[27:0] = {instr[25:0], 2'b00};
    return tgt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ---- fetch_buffer: DEPTH-entry synchronous FIFO of {instr, pc} with flush -- rev 1.0 ----
`default_nettype none

module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [31:0]             i_instr,
  input  logic [31:0]             i_pc,
  output logic [31:0]             o_instr,
  output logic [31:0]             o_pc,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= '{instr: i_instr, pc: i_pc};
  end

  assign o_instr = r_mem[r_rd_ptr].instr;
  assign o_pc    = r_mem[r_rd_ptr].pc;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(i_push && !i_pop && (r_count == c_full)));

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---- fetch_unit: MIPS fetch stage (PC, imem requests, instruction buffer, redirect) -- rev 1.0 ----
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        dobranch,
  input  logic        dojump
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] c_depth = CW'(BUF_DEPTH);

  logic [1:0]    r_state, w_state_next;
  logic [31:0]   r_fetch_pc, w_pc_next;
  logic [31:0]   r_req_addr;
  logic          r_drop, w_drop_next;
  logic          w_xfer, w_redirect, w_push, w_empty;
  logic [31:0]   w_target, w_head_instr, w_head_pc;
  logic [CW-1:0] w_count, w_count_next;

  assign w_xfer     = ~w_empty & instr_ready;
  assign w_redirect = w_xfer & (dobranch | dojump);
  assign w_target   = dojump ? jump_target(w_head_pc, w_head_instr)
                             : branch_target(w_head_pc, w_head_instr);
  assign w_push     = (r_state == S_WAIT) & imem_rvalid & ~r_drop & ~w_redirect;

  // Credit is judged on next-cycle occupancy so a word landing now is counted.
  always_comb begin
    w_count_next = w_count;
    if (w_redirect) w_count_next = '0;
    else if (w_push && !w_xfer) w_count_next = w_count + 1'b1;
    else if (!w_push && w_xfer) w_count_next = w_count - 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_count_next < c_depth) w_state_next = S_REQ;
      S_REQ:   if (imem_gnt) w_state_next = S_WAIT;
      S_WAIT:  if (imem_rvalid) w_state_next = (w_count_next < c_depth) ? S_REQ : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A request already in flight at redirect is stale: it must not advance the PC.
  always_comb begin
    w_pc_next = r_fetch_pc;
    if (w_redirect) w_pc_next = w_target;
    else if (r_state == S_REQ && imem_gnt && !r_drop) w_pc_next = r_fetch_pc + 32'd4;
  end

  always_comb begin
    w_drop_next = r_drop;
    if (r_state == S_WAIT && imem_rvalid) w_drop_next = 1'b0;
    else if (w_redirect && r_state != S_IDLE) w_drop_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_pc_next;
      r_drop     <= w_drop_next;
      if (w_state_next == S_REQ && r_state != S_REQ) r_req_addr <= w_pc_next;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_xfer),
    .i_flush (w_redirect),
    .i_instr (imem_rdata),
    .i_pc    (r_req_addr),
    .o_instr (w_head_instr),
    .o_pc    (w_head_pc),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_req_addr;
  assign instr_valid = ~w_empty;
  assign instr       = w_empty ? 32'h0 : w_head_instr;
  assign instr_pc    = w_empty ? 32'h0 : w_head_pc;

endmodule

`default_nettype wire
